lsu_handshake: RTL and testbench

- Parametrised load/store unit that replaces the fixed single-cycle data-memory path (direct SRAM access plus separate load filter) with a valid/ready memory interface.
- Accepts one core access at a time and aligns store data and byte enables to the memory word.
- Waits for the memory response, or times out, then returns sign- or zero-extended load data.
- Flags misaligned or illegal accesses without touching memory.
- Sits between the core's execute stage and the data memory; `busy` stalls the PC.

---
 rtl/lsu_handshake_if.sv | 53 +++++
 rtl/lsu_handshake.sv | 230 +++++++++++++++++++++++
 tb/tb_lsu_handshake.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_handshake_if.sv
// Handshake bundles for the load/store unit: the core-facing request/response
// channel and the valid/ready data-memory channel.

// Core side: the execute stage is the master, the LSU is the slave.
interface lsu_core_if #(
  parameter int XLEN = 32
);
  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic [2:0]      req_func3;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic            resp_valid;
  logic [XLEN-1:0] resp_rdata;
  logic            resp_err;
  logic            busy;

  modport master (
    output req_valid, req_we, req_func3, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, busy
  );

  modport slave (
    input  req_valid, req_we, req_func3, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err, busy
  );
endinterface

// Memory side: the LSU is the master, the data memory is the slave.
interface lsu_mem_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 16
);
  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [XLEN/8-1:0] mem_we;
  logic [XLEN-1:0]   mem_wdata;
  logic              mem_rvalid;
  logic [XLEN-1:0]   mem_rdata;
  logic              mem_err;

  modport master (
    output mem_valid, mem_addr, mem_we, mem_wdata,
    input  mem_ready, mem_rvalid, mem_rdata, mem_err
  );

  modport slave (
    input  mem_valid, mem_addr, mem_we, mem_wdata,
    output mem_ready, mem_rvalid, mem_rdata, mem_err
  );
endinterface

// File: rtl/lsu_handshake.sv
// Load/store unit with a valid/ready data-memory port. One access in flight;
// store data and byte enables are lane-aligned to the memory word, load data
// is shifted down and sign/zero extended. Misaligned or illegal accesses are
// answered with an error without issuing a memory request. Accesses that sit
// in REQ+WAIT for TIMEOUT cycles are aborted with an error.
module lsu_handshake #(
  parameter int XLEN    = 32,
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  lsu_core_if.slave  core,
  lsu_mem_if.master  mem
);

  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);
  localparam int CNTW = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(NB - 1);
  localparam logic [CNTW-1:0]   CNT_LAST = CNTW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    RESP = 3'd3,
    ERR  = 3'd4
  } state_t;

  state_t            state_r;
  logic [CNTW-1:0]   cnt_r;
  logic [2:0]        func3_r;
  logic [OFFW-1:0]   off_r;
  logic              we_r;

  logic              req_ready_r;
  logic              busy_r;
  logic              resp_valid_r;
  logic              resp_err_r;
  logic [XLEN-1:0]   resp_rdata_r;
  logic              mem_valid_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [NB-1:0]     mem_we_r;
  logic [XLEN-1:0]   mem_wdata_r;

  logic [OFFW-1:0]   off_s;
  logic [1:0]        size_s;
  logic              illegal_s;
  logic              misalign_s;
  logic [NB-1:0]     size_mask_s;
  logic [XLEN-1:0]   size_bits_s;
  logic [NB-1:0]     we_s;
  logic [XLEN-1:0]   wdata_s;
  logic [ADDR_W-1:0] addr_s;

  logic [XLEN-1:0]   shifted_s;
  logic [XLEN-1:0]   load_s;
  logic              sign_s;
  int                load_bits_s;

  // Address bits above the memory window are not routed anywhere.
  logic              unused_addr_s;
  assign unused_addr_s = ^core.req_addr[XLEN-1:ADDR_W];

  // Decode the incoming request: legality, alignment and lane placement.
  always_comb begin
    off_s       = core.req_addr[OFFW-1:0];
    size_s      = core.req_func3[1:0];
    size_mask_s = '0;
    size_bits_s = '0;
    for (int i = 0; i < NB; i++) begin
      size_mask_s[i]        = (i < int'(32'd1 << size_s)) ? 1'b1 : 1'b0;
      size_bits_s[8*i +: 8] = {8{size_mask_s[i]}};
    end
    we_s    = size_mask_s << off_s;
    wdata_s = (core.req_wdata & size_bits_s) << {off_s, 3'b000};
    addr_s  = core.req_addr[ADDR_W-1:0] & ~OFF_MASK;

    illegal_s = 1'b0;
    case (core.req_func3)
      3'b000, 3'b001, 3'b010: illegal_s = 1'b0;
      3'b011:                 illegal_s = (XLEN == 32);
      3'b100, 3'b101:         illegal_s = core.req_we;
      3'b110:                 illegal_s = core.req_we | (XLEN == 32);
      3'b111:                 illegal_s = 1'b1;
      default:                illegal_s = 1'b1;
    endcase

    misalign_s = 1'b0;
    case (size_s)
      2'd0:    misalign_s = 1'b0;
      2'd1:    misalign_s = core.req_addr[0];
      2'd2:    misalign_s = (core.req_addr[1:0] != 2'b00);
      2'd3:    misalign_s = (core.req_addr[2:0] != 3'b000);
      default: misalign_s = 1'b0;
    endcase
  end

  // Shift the returned word down to its lane and sign/zero extend it.
  always_comb begin
    shifted_s   = mem.mem_rdata >> {off_r, 3'b000};
    load_bits_s = XLEN;
    sign_s      = 1'b0;
    case (func3_r[1:0])
      2'd0:    begin load_bits_s = 32'sd8;  sign_s = shifted_s[7];      end
      2'd1:    begin load_bits_s = 32'sd16; sign_s = shifted_s[15];     end
      2'd2:    begin load_bits_s = 32'sd32; sign_s = shifted_s[31];     end
      default: begin load_bits_s = XLEN;    sign_s = shifted_s[XLEN-1]; end
    endcase
    // funct3[2] selects the unsigned variants.
    sign_s = sign_s & ~func3_r[2];
    load_s = '0;
    for (int i = 0; i < XLEN; i++) begin
      load_s[i] = (i < load_bits_s) ? shifted_s[i] : sign_s;
    end
  end

  // Access sequencer: accept, request, wait for response or timeout, respond.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      cnt_r        <= '0;
      func3_r      <= 3'd0;
      off_r        <= '0;
      we_r         <= 1'b0;
      req_ready_r  <= 1'b1;
      busy_r       <= 1'b0;
      resp_valid_r <= 1'b0;
      resp_err_r   <= 1'b0;
      resp_rdata_r <= '0;
      mem_valid_r  <= 1'b0;
      mem_addr_r   <= '0;
      mem_we_r     <= '0;
      mem_wdata_r  <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (core.req_valid) begin
            func3_r     <= core.req_func3;
            off_r       <= off_s;
            we_r        <= core.req_we;
            req_ready_r <= 1'b0;
            busy_r      <= 1'b1;
            cnt_r       <= '0;
            if (illegal_s || misalign_s) begin
              // Rejected without touching memory.
              state_r      <= ERR;
              resp_valid_r <= 1'b1;
              resp_err_r   <= 1'b1;
              resp_rdata_r <= '0;
            end else begin
              state_r     <= REQ;
              mem_valid_r <= 1'b1;
              mem_addr_r  <= addr_s;
              mem_we_r    <= core.req_we ? we_s : '0;
              mem_wdata_r <= core.req_we ? wdata_s : '0;
            end
          end
        end

        REQ: begin
          if (cnt_r == CNT_LAST) begin
            state_r      <= RESP;
            mem_valid_r  <= 1'b0;
            resp_valid_r <= 1'b1;
            resp_err_r   <= 1'b1;
            resp_rdata_r <= '0;
          end else if (mem.mem_ready) begin
            // Any rvalid in the accept cycle is ignored: memory answers later.
            state_r     <= WAIT;
            mem_valid_r <= 1'b0;
            cnt_r       <= cnt_r + CNTW'(1);
          end else begin
            cnt_r <= cnt_r + CNTW'(1);
          end
        end

        WAIT: begin
          if (cnt_r == CNT_LAST) begin
            state_r      <= RESP;
            resp_valid_r <= 1'b1;
            resp_err_r   <= 1'b1;
            resp_rdata_r <= '0;
          end else if (mem.mem_rvalid) begin
            state_r      <= RESP;
            resp_valid_r <= 1'b1;
            resp_err_r   <= mem.mem_err;
            resp_rdata_r <= (mem.mem_err || we_r) ? '0 : load_s;
          end else begin
            cnt_r <= cnt_r + CNTW'(1);
          end
        end

        RESP, ERR: begin
          // One-cycle response pulse, then back to idle.
          state_r      <= IDLE;
          req_ready_r  <= 1'b1;
          busy_r       <= 1'b0;
          resp_valid_r <= 1'b0;
          resp_err_r   <= 1'b0;
          resp_rdata_r <= '0;
          cnt_r        <= '0;
        end

        default: begin
          state_r      <= IDLE;
          req_ready_r  <= 1'b1;
          busy_r       <= 1'b0;
          resp_valid_r <= 1'b0;
          resp_err_r   <= 1'b0;
          resp_rdata_r <= '0;
          mem_valid_r  <= 1'b0;
          cnt_r        <= '0;
        end
      endcase
    end
  end

  assign core.req_ready  = req_ready_r;
  assign core.busy       = busy_r;
  assign core.resp_valid = resp_valid_r;
  assign core.resp_err   = resp_err_r;
  assign core.resp_rdata = resp_rdata_r;
  assign mem.mem_valid   = mem_valid_r;
  assign mem.mem_addr    = mem_addr_r;
  assign mem.mem_we      = mem_we_r;
  assign mem.mem_wdata   = mem_wdata_r;

endmodule

// File: tb/tb_lsu_handshake.sv
// Scoreboard bench for lsu_handshake: a 32-bit instance (TIMEOUT=4) and a
// 64-bit instance (TIMEOUT=255) driven with directed accesses. Expected
// responses are queued at issue time and popped by per-instance monitors.
module tb_lsu_handshake;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst32;
  logic rst64;
  int   checks = 0;
  int   errors = 0;
  exp_t q32[$];
  exp_t q64[$];

  always #5 clk = ~clk;

  lsu_core_if #(.XLEN(32))              c32 ();
  lsu_mem_if  #(.XLEN(32), .ADDR_W(16)) m32 ();
  lsu_core_if #(.XLEN(64))              c64 ();
  lsu_mem_if  #(.XLEN(64), .ADDR_W(16)) m64 ();

  lsu_handshake #(.XLEN(32), .ADDR_W(16), .TIMEOUT(4)) dut32 (
    .clk (clk), .rst (rst32), .core (c32.slave), .mem (m32.master)
  );

  lsu_handshake #(.XLEN(64), .ADDR_W(16), .TIMEOUT(255)) dut64 (
    .clk (clk), .rst (rst64), .core (c64.slave), .mem (m64.master)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Response monitor for the 32-bit instance.
  always @(negedge clk) begin
    exp_t e;
    if (c32.resp_valid === 1'b1) begin
      if (q32.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL resp32_unexpected: got resp_valid=1 expected no response");
      end else begin
        e = q32.pop_front();
        chk("resp32_rdata", {32'h0, c32.resp_rdata}, {32'h0, e.rdata[31:0]});
        chk("resp32_err", {63'h0, c32.resp_err}, {63'h0, e.err});
      end
    end
  end

  // Response monitor for the 64-bit instance.
  always @(negedge clk) begin
    exp_t e;
    if (c64.resp_valid === 1'b1) begin
      if (q64.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL resp64_unexpected: got resp_valid=1 expected no response");
      end else begin
        e = q64.pop_front();
        chk("resp64_rdata", c64.resp_rdata, e.rdata);
        chk("resp64_err", {63'h0, c64.resp_err}, {63'h0, e.err});
      end
    end
  end

  task automatic drive_req(input bit is64, input logic v, input logic we,
                           input logic [2:0] f3, input logic [63:0] addr,
                           input logic [63:0] wdata);
    if (is64) begin
      c64.req_valid = v; c64.req_we = we; c64.req_func3 = f3;
      c64.req_addr = addr; c64.req_wdata = wdata;
    end else begin
      c32.req_valid = v; c32.req_we = we; c32.req_func3 = f3;
      c32.req_addr = addr[31:0]; c32.req_wdata = wdata[31:0];
    end
  endtask

  task automatic drive_mem(input bit is64, input logic ready, input logic rvalid,
                           input logic [63:0] rdata, input logic err);
    if (is64) begin
      m64.mem_ready = ready; m64.mem_rvalid = rvalid;
      m64.mem_rdata = rdata; m64.mem_err = err;
    end else begin
      m32.mem_ready = ready; m32.mem_rvalid = rvalid;
      m32.mem_rdata = rdata[31:0]; m32.mem_err = err;
    end
  endtask

  task automatic wait_ready(input bit is64);
    int n = 0;
    while (n < 20 && !(is64 ? c64.req_ready : c32.req_ready)) begin
      @(posedge clk); #1;
      n++;
    end
    if (n == 20) begin
      checks++;
      errors++;
      $display("FAIL req_ready_wait: got req_ready=0 for 20 cycles expected 1");
    end
  endtask

  // One access at minimum latency; early=1 means the unit must reject it.
  task automatic access(input bit is64, input logic we, input logic [2:0] f3,
                        input logic [63:0] addr, input logic [63:0] wdata,
                        input logic [63:0] rdata, input logic merr, input bit early,
                        input logic [15:0] e_maddr, input logic [7:0] e_we,
                        input logic [63:0] e_wdata, input logic [63:0] e_rdata,
                        input logic e_err);
    exp_t e;
    wait_ready(is64);
    e.rdata = e_rdata;
    e.err   = e_err;
    if (is64) q64.push_back(e); else q32.push_back(e);
    drive_req(is64, 1'b1, we, f3, addr, wdata);
    @(posedge clk); #1;
    drive_req(is64, 1'b0, 1'b0, 3'd0, 64'h0, 64'h0);
    if (early) begin
      @(negedge clk);
      chk("no_mem_valid", {63'h0, is64 ? m64.mem_valid : m32.mem_valid}, 64'h0);
      @(posedge clk); #1;
    end else begin
      drive_mem(is64, 1'b1, 1'b0, 64'h0, 1'b0);
      @(negedge clk);
      chk("mem_valid", {63'h0, is64 ? m64.mem_valid : m32.mem_valid}, 64'h1);
      chk("busy", {63'h0, is64 ? c64.busy : c32.busy}, 64'h1);
      chk("mem_addr", {48'h0, is64 ? m64.mem_addr : m32.mem_addr}, {48'h0, e_maddr});
      chk("mem_we", {56'h0, is64 ? m64.mem_we : {4'h0, m32.mem_we}}, {56'h0, e_we});
      chk("mem_wdata", is64 ? m64.mem_wdata : {32'h0, m32.mem_wdata}, e_wdata);
      @(posedge clk); #1;
      drive_mem(is64, 1'b0, 1'b1, rdata, merr);
      @(posedge clk); #1;
      drive_mem(is64, 1'b0, 1'b0, 64'h0, 1'b0);
      @(negedge clk);
      chk("resp_latency", {63'h0, is64 ? c64.resp_valid : c32.resp_valid}, 64'h1);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    exp_t e;
    rst32 = 1'b1;
    rst64 = 1'b1;
    drive_req(1'b0, 1'b0, 1'b0, 3'd0, 64'h0, 64'h0);
    drive_req(1'b1, 1'b0, 1'b0, 3'd0, 64'h0, 64'h0);
    drive_mem(1'b0, 1'b0, 1'b0, 64'h0, 1'b0);
    drive_mem(1'b1, 1'b0, 1'b0, 64'h0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst32 = 1'b0;
    rst64 = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_req_ready", {63'h0, c32.req_ready}, 64'h1);
    chk("rst_busy", {63'h0, c32.busy}, 64'h0);
    chk("rst_resp_valid", {63'h0, c32.resp_valid}, 64'h0);
    chk("rst_resp_err", {63'h0, c32.resp_err}, 64'h0);
    chk("rst_resp_rdata", {32'h0, c32.resp_rdata}, 64'h0);
    chk("rst_mem_valid", {63'h0, m32.mem_valid}, 64'h0);
    chk("rst_mem_addr", {48'h0, m32.mem_addr}, 64'h0);
    chk("rst_mem_we", {60'h0, m32.mem_we}, 64'h0);
    chk("rst_mem_wdata", {32'h0, m32.mem_wdata}, 64'h0);
    chk("rst64_req_ready", {63'h0, c64.req_ready}, 64'h1);
    @(posedge clk); #1;

    // 32-bit stores: SW, SB, SH (store responses carry rdata 0)
    access(0, 1, 3'b010, 64'h0104, 64'hDEADBEEF, 64'h12345678, 0, 0, 16'h0104, 8'h0F, 64'hDEADBEEF, 64'h0, 0);
    access(0, 1, 3'b000, 64'h0013, 64'h000000A5, 64'h0, 0, 0, 16'h0010, 8'h08, 64'hA5000000, 64'h0, 0);
    access(0, 1, 3'b001, 64'h0022, 64'h1234BEEF, 64'h0, 0, 0, 16'h0020, 8'h0C, 64'hBEEF0000, 64'h0, 0);
    // 32-bit loads: LB, LBU, LH, LHU
    access(0, 0, 3'b000, 64'h0013, 64'h0, 64'hA5000000, 0, 0, 16'h0010, 8'h00, 64'h0, 64'hFFFFFFA5, 0);
    access(0, 0, 3'b100, 64'h0013, 64'h0, 64'hA5000000, 0, 0, 16'h0010, 8'h00, 64'h0, 64'h000000A5, 0);
    access(0, 0, 3'b001, 64'h0002, 64'h0, 64'h80010000, 0, 0, 16'h0000, 8'h00, 64'h0, 64'hFFFF8001, 0);
    access(0, 0, 3'b101, 64'h0002, 64'h0, 64'h80010000, 0, 0, 16'h0000, 8'h00, 64'h0, 64'h00008001, 0);
    // Rejected: misaligned LW, LD on 32-bit, unsigned-store code, funct3 111
    access(0, 0, 3'b010, 64'h0006, 64'h0, 64'h0, 0, 1, 16'h0, 8'h0, 64'h0, 64'h0, 1);
    access(0, 0, 3'b011, 64'h0008, 64'h0, 64'h0, 0, 1, 16'h0, 8'h0, 64'h0, 64'h0, 1);
    access(0, 1, 3'b100, 64'h0010, 64'h0, 64'h0, 0, 1, 16'h0, 8'h0, 64'h0, 64'h0, 1);
    access(0, 0, 3'b111, 64'h0010, 64'h0, 64'h0, 0, 1, 16'h0, 8'h0, 64'h0, 64'h0, 1);
    // Bus error on a load
    access(0, 0, 3'b010, 64'h000C, 64'h0, 64'h55555555, 1, 0, 16'h000C, 8'h00, 64'h0, 64'h0, 1);

    // Backpressure then timeout (TIMEOUT=4); a late rvalid must be ignored
    wait_ready(0);
    e.rdata = 64'h0;
    e.err   = 1'b1;
    q32.push_back(e);
    drive_req(0, 1'b1, 1'b0, 3'b010, 64'h0020, 64'h0);
    @(posedge clk); #1;
    drive_req(0, 1'b0, 1'b0, 3'd0, 64'h0, 64'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("hold_mem_valid", {63'h0, m32.mem_valid}, 64'h1);
      chk("hold_mem_addr", {48'h0, m32.mem_addr}, 64'h0020);
      chk("hold_mem_we", {60'h0, m32.mem_we}, 64'h0);
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    drive_mem(0, 1'b0, 1'b1, 64'hFFFFFFFF, 1'b0);
    @(negedge clk);
    chk("timeout_resp_valid", {63'h0, c32.resp_valid}, 64'h1);
    chk("timeout_mem_valid", {63'h0, m32.mem_valid}, 64'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    drive_mem(0, 1'b0, 1'b0, 64'h0, 1'b0);
    @(negedge clk);
    chk("timeout_idle", {63'h0, c32.req_ready}, 64'h1);
    @(posedge clk); #1;

    // Reset while in WAIT: no response for the aborted access
    wait_ready(0);
    drive_req(0, 1'b1, 1'b0, 3'b010, 64'h0040, 64'h0);
    @(posedge clk); #1;
    drive_req(0, 1'b0, 1'b0, 3'd0, 64'h0, 64'h0);
    drive_mem(0, 1'b1, 1'b0, 64'h0, 1'b0);
    @(posedge clk); #1;
    drive_mem(0, 1'b0, 1'b0, 64'h0, 1'b0);
    rst32 = 1'b1;
    @(posedge clk); #1;
    rst32 = 1'b0;
    @(negedge clk);
    chk("abort_req_ready", {63'h0, c32.req_ready}, 64'h1);
    chk("abort_mem_valid", {63'h0, m32.mem_valid}, 64'h0);
    chk("abort_resp_valid", {63'h0, c32.resp_valid}, 64'h0);
    chk("abort_busy", {63'h0, c32.busy}, 64'h0);
    @(posedge clk); #1;
    access(0, 0, 3'b010, 64'h0008, 64'h0, 64'hCAFEF00D, 0, 0, 16'h0008, 8'h00, 64'h0, 64'hCAFEF00D, 0);

    // 64-bit instance: LWU, LW, SD, SW upper lane, LD, LB, rejected WU store
    access(1, 0, 3'b110, 64'h000C, 64'h0, 64'h8000000000000000, 0, 0, 16'h0008, 8'h00, 64'h0, 64'h0000000080000000, 0);
    access(1, 0, 3'b010, 64'h000C, 64'h0, 64'h8000000000000000, 0, 0, 16'h0008, 8'h00, 64'h0, 64'hFFFFFFFF80000000, 0);
    access(1, 1, 3'b011, 64'h0010, 64'h0123456789ABCDEF, 64'h0, 0, 0, 16'h0010, 8'hFF, 64'h0123456789ABCDEF, 64'h0, 0);
    access(1, 1, 3'b010, 64'h000C, 64'hDEADBEEF, 64'h0, 0, 0, 16'h0008, 8'hF0, 64'hDEADBEEF00000000, 64'h0, 0);
    access(1, 0, 3'b011, 64'h0008, 64'h0, 64'h8877665544332211, 0, 0, 16'h0008, 8'h00, 64'h0, 64'h8877665544332211, 0);
    access(1, 0, 3'b000, 64'h000F, 64'h0, 64'h7F00000000000000, 0, 0, 16'h0008, 8'h00, 64'h0, 64'h000000000000007F, 0);
    access(1, 1, 3'b110, 64'h0008, 64'h0, 64'h0, 0, 1, 16'h0, 8'h0, 64'h0, 64'h0, 1);

    repeat (5) @(posedge clk);
    chk("q32_drained", 64'(q32.size()), 64'h0);
    chk("q64_drained", 64'(q64.size()), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Bound the whole run.
  initial begin
    #50000;
    $display("FAIL watchdog: got no finish expected finish within 50000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
